// File: rtl/quad_encoder_tx.sv
// quad_encoder_tx
// Generates rotary-encoder style quadrature A/B waveforms from commanded step
// counts. A command carries a direction, a number of transitions and the number
// of clock cycles between transitions. A signed 16-bit position tracks every
// emitted transition. The A/B phase persists across commands and aborts, so
// consecutive commands continue one seamless quadrature stream.
module quad_encoder_tx #(
    parameter int STEP_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0]  cmd_period,
    input  logic              abort,
    output logic              enc_a,
    output logic              enc_b,
    output logic              busy,
    output logic              done,
    output logic [15:0]       position
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Latched command fields.
    logic              dir_q;
    logic [STEP_W-1:0] steps_q;
    logic [DIV_W-1:0]  period_q;

    // Cycles left until the next scheduled transition.
    logic [DIV_W-1:0]  cnt_q;

    // Quadrature outputs and position, all held in flops.
    logic              a_q;
    logic              b_q;
    logic [15:0]       pos_q;
    logic              done_q;

    // Decoded control strobes.
    logic              accept;
    logic              step_now;
    logic              last_step;
    logic              zero_cmd;
    logic [DIV_W-1:0]  period_eff;

    // A period of 0 would mean "no wait at all"; it is run as 1 cycle instead.
    assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

    // Advance the Gray-coded phase one step. The table for (A,B) is
    // forward 00->10->11->01->00 and reverse 00->01->11->10->00, which reduces
    // to: forward A<=~B, B<=A; reverse A<=B, B<=~A. Only one bit ever changes.
    function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic fwd);
        logic [1:0] nxt;
        if (fwd) begin
            nxt = {~ab[0], ab[1]};
        end else begin
            nxt = {ab[0], ~ab[1]};
        end
        return nxt;
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values and the update order inside the block is irrelevant.
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus handshake/status outputs and control strobes.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        zero_cmd  = 1'b0;
        step_now  = 1'b0;
        last_step = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                // abort is deliberately ignored here: a simultaneous command
                // is still taken.
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_steps == '0) begin
                        zero_cmd = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    // abort beats a transition scheduled for the same edge
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    step_now = 1'b1;
                    if (steps_q == STEP_W'(1)) begin
                        last_step = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch: direction, remaining steps and effective period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dir_q    <= 1'b0;
            steps_q  <= '0;
            period_q <= DIV_W'(1);
        end else if (accept) begin
            dir_q    <= cmd_dir;
            steps_q  <= cmd_steps;
            period_q <= period_eff;
        end else if (step_now) begin
            steps_q  <= steps_q - STEP_W'(1);
        end
    end

    // Interval counter: loaded with period-1 on accept, counts down while
    // running and reloads after each emitted transition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= period_eff - DIV_W'(1);
        end else if (state_q == RUN) begin
            if (cnt_q == '0) begin
                cnt_q <= period_q - DIV_W'(1);
            end else begin
                cnt_q <= cnt_q - DIV_W'(1);
            end
        end
    end

    // Quadrature phase and signed position; both move only on emitted edges.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q   <= 1'b0;
            b_q   <= 1'b0;
            pos_q <= '0;
        end else if (step_now) begin
            {a_q, b_q} <= next_phase({a_q, b_q}, dir_q);
            // two's-complement wrap in both directions is intended
            pos_q      <= dir_q ? (pos_q + 16'd1) : (pos_q - 16'd1);
        end
    end

    // One-cycle completion pulse for a normal finish or an empty command.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_step | zero_cmd;
        end
    end

    assign enc_a    = a_q;
    assign enc_b    = b_q;
    assign done     = done_q;
    assign position = pos_q;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// tb_quad_encoder_tx
// Directed plus randomized commands against a timing-formula reference model:
// after k*P edges of a command accepted with period P, k transitions have been
// emitted. An independent quadrature decoder cross-checks the position output.
module tb_quad_encoder_tx;

    localparam int STEP_W = 8;
    localparam int DIV_W  = 16;

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;
    logic [DIV_W-1:0]  cmd_period;
    logic              abort;
    logic              enc_a;
    logic              enc_b;
    logic              busy;
    logic              done;
    logic [15:0]       position;

    int                checks;
    int                errors;

    // reference model state
    int                m_phase;
    logic [15:0]       m_pos;

    // independent quadrature decoder state
    int                dec_prev;
    logic [15:0]       dec_count;
    int                dec_bad;

    // random-loop scratch
    bit                r_dir;
    int                r_n;
    int                r_p;
    int                r_pe;
    int                r_ak;
    int                r_ad;
    bit                r_hold;
    int                r_gap;

    quad_encoder_tx #(
        .STEP_W(STEP_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .abort     (abort),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang.
    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mod4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    // Quadrature position index -> (A,B): forward order 00,10,11,01.
    function automatic logic [1:0] enc_of(input int ph);
        logic [1:0] v;
        case (mod4(ph))
            0:       v = 2'b00;
            1:       v = 2'b10;
            2:       v = 2'b11;
            default: v = 2'b01;
        endcase
        return v;
    endfunction

    function automatic int idx_of(input logic [1:0] ab);
        int v;
        case (ab)
            2'b00:   v = 0;
            2'b10:   v = 1;
            2'b11:   v = 2;
            default: v = 3;
        endcase
        return v;
    endfunction

    // Advance to the next falling edge and feed the decoder.
    task automatic tick();
        int cur;
        int diff;
        @(negedge clk);
        cur  = idx_of({enc_a, enc_b});
        diff = mod4(cur - dec_prev);
        if (diff == 1) dec_count++;
        else if (diff == 3) dec_count--;
        else if (diff == 2) dec_bad++;
        dec_prev = cur;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("ready_timeout", cmd_ready, 1);
    endtask

    // Issue one command and check every cycle until it settles.
    // abort_k >= 0: raise abort abort_d cycles after transition abort_k.
    task automatic run_cmd(input bit dir, input int n, input int p, input int abort_k,
                           input int abort_d, input bit idle_abort, input bit hold_valid);
        int          peff;
        int          total;
        int          c_abort;
        int          last;
        int          sign;
        int          k;
        int          base_ph;
        bit          aborted;
        bit          exp_busy;
        bit          exp_done;
        logic [15:0] base_pos;
        logic [15:0] exp_pos;

        peff     = (p == 0) ? 1 : p;
        total    = n * peff;
        c_abort  = (abort_k >= 0) ? abort_k * peff + abort_d : -1;
        sign     = dir ? 1 : -1;
        base_ph  = m_phase;
        base_pos = m_pos;
        k        = 0;
        last     = (n == 0) ? 1 : ((c_abort >= 0) ? c_abort + 2 : total + 1);

        wait_ready();
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = 8'(n);
        cmd_period = 16'(p);
        abort      = idle_abort;
        tick();
        abort      = 1'b0;
        cmd_valid  = hold_valid && (n > 0);
        cmd_dir    = 1'($urandom);
        cmd_steps  = 8'($urandom);
        cmd_period = 16'($urandom);

        for (int c = 0; c <= last; c++) begin
            if (c > 0) tick();
            aborted = (c_abort >= 0) && (c > c_abort);
            if (aborted) k = abort_k;
            else k = ((c / peff) < n) ? (c / peff) : n;
            if (n == 0 || aborted) begin
                exp_busy = 1'b0;
                exp_done = (n == 0) && (c == 0);
            end else begin
                exp_busy = (c < total);
                exp_done = (c == total);
            end
            exp_pos = base_pos + 16'(sign * k);
            check("enc_ab", {enc_a, enc_b}, enc_of(base_ph + sign * k));
            check("position", position, exp_pos);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("cmd_ready", cmd_ready, !exp_busy);
            if (c == c_abort) begin
                abort     = 1'b1;
                cmd_valid = 1'b0;
            end
            if (c == c_abort + 1) abort = 1'b0;
            if (c == total) cmd_valid = 1'b0;
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        m_phase   = mod4(base_ph + sign * k);
        m_pos     = base_pos + 16'(sign * k);
        check("decoder_count", position, dec_count);
        check("decoder_legal", dec_bad, 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_phase    = 0;
        m_pos      = '0;
        dec_prev   = 0;
        dec_count  = '0;
        dec_bad    = 0;
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;

        // reset values, visible the cycle after the first reset edge
        @(negedge clk);
        check("rst_enc", {enc_a, enc_b}, 2'b00);
        check("rst_pos", position, 16'd0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // forward 4 steps, period 3 from reset
        run_cmd(1'b1, 4, 3, -1, 0, 1'b0, 1'b0);
        check("fwd4_pos", position, 16'd4);
        check("fwd4_enc", {enc_a, enc_b}, 2'b00);

        // reverse 5 steps on consecutive cycles; phase 01 retained
        run_cmd(1'b0, 5, 1, -1, 0, 1'b0, 1'b0);
        check("rev5_enc", {enc_a, enc_b}, 2'b01);
        check("rev5_pos", position, 16'hFFFF);
        run_cmd(1'b1, 1, 1, -1, 0, 1'b0, 1'b0);
        check("fwd1_enc", {enc_a, enc_b}, 2'b00);

        // period 0 runs as period 1; empty command pulses done only
        run_cmd(1'b1, 3, 0, -1, 0, 1'b0, 1'b0);
        run_cmd(1'b0, 2, 1, -1, 0, 1'b0, 1'b0);
        run_cmd(1'b1, 0, 2, -1, 0, 1'b0, 1'b0);

        // abort after 2 of 10 forward steps, and abort on a transition edge
        run_cmd(1'b1, 10, 4, 2, 1, 1'b0, 1'b0);
        run_cmd(1'b0, 6, 3, 1, 2, 1'b0, 1'b0);

        // abort in IDLE together with cmd_valid: command still taken
        run_cmd(1'b1, 2, 2, -1, 0, 1'b1, 1'b0);

        // cmd_valid held high while busy must not be accepted
        run_cmd(1'b0, 3, 2, -1, 0, 1'b0, 1'b1);

        // randomized commands with idle gaps
        for (int i = 0; i < 30; i++) begin
            r_dir  = 1'($urandom_range(0, 1));
            r_n    = $urandom_range(0, 12);
            r_p    = $urandom_range(0, 5);
            r_pe   = (r_p == 0) ? 1 : r_p;
            r_ak   = -1;
            r_ad   = 0;
            r_hold = 1'b0;
            if (r_n > 0 && $urandom_range(0, 3) == 0) begin
                r_ak = $urandom_range(0, r_n - 1);
                r_ad = $urandom_range(0, r_pe - 1);
                if (r_ak == 0 && r_ad == 0) r_ak = -1;
            end
            if (r_ak < 0) r_hold = 1'($urandom_range(0, 1));
            run_cmd(r_dir, r_n, r_p, r_ak, r_ad, 1'($urandom_range(0, 1)), r_hold);
            r_gap = $urandom_range(0, 3);
            for (int g = 0; g < r_gap; g++) begin
                tick();
                check("gap_busy", busy, 0);
                check("gap_done", done, 0);
                check("gap_enc", {enc_a, enc_b}, enc_of(m_phase));
            end
        end

        // synchronous reset in the middle of a run discards the command
        wait_ready();
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = 8'd10;
        cmd_period = 16'd2;
        tick();
        cmd_valid  = 1'b0;
        repeat (5) tick();
        check("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_enc", {enc_a, enc_b}, 2'b00);
        check("midrst_pos", position, 16'd0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cmd_ready, 1);
        check("midrst_done", done, 0);
        m_phase   = 0;
        m_pos     = '0;
        dec_prev  = 0;
        dec_count = '0;
        repeat (3) tick();
        check("postrst_enc", {enc_a, enc_b}, 2'b00);
        check("postrst_busy", busy, 0);

        // position wrap: 32767 forward edges, then one more, then one back
        for (int i = 0; i < 128; i++) run_cmd(1'b1, 255, 1, -1, 0, 1'b0, 1'b0);
        run_cmd(1'b1, 127, 1, -1, 0, 1'b0, 1'b0);
        check("wrap_preload", position, 16'h7FFF);
        run_cmd(1'b1, 1, 1, -1, 0, 1'b0, 1'b0);
        check("wrap_fwd", position, 16'h8000);
        run_cmd(1'b0, 1, 1, -1, 0, 1'b0, 1'b0);
        check("wrap_rev", position, 16'h7FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
